// File: rtl/spi_param_bridge.sv
// SPI command decoder and parameter register file for the DDA solver.
// Decodes 16-bit register reads and writes from received SPI bytes.
// Ports:
//   clk, rst            clock, async active-high reset
//   cs_n                chip select, high aborts the current frame
//   rx_dv, rx_byte      received byte strobe and data
//   tx_dv, tx_byte      byte preload strobe and data for the slave
//   x, y                live solver state words
//   params              flattened parameter words, word i at [i*N +: N]
//   en_dda              solver run enable (control bit0)
//   param_wr            pulse one cycle after a committed write
// Macro DDA_SNAPSHOT_EN: latch x/y on the read command so that
// the hi and lo bytes come from one coherent 16-bit value.
module spi_param_bridge #(
   parameter int N        = 16,
   parameter int REG_SIZE = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cs_n,
   input  logic                  rx_dv,
   input  logic [7:0]            rx_byte,
   output logic                  tx_dv,
   output logic [7:0]            tx_byte,
   input  logic [N-1:0]          x,
   input  logic [N-1:0]          y,
   output logic [N*REG_SIZE-1:0] params,
   output logic                  en_dda,
   output logic                  param_wr
);

   typedef enum logic [2:0] {
      IDLE,
      WR_HI,
      WR_LO,
      RD_HI,
      RD_LO
   } state_t;

   state_t         state;
   state_t         state_nx;
   logic [N-1:0]   regs [REG_SIZE];
   logic [7:0]     stage;
   logic [3:0]     addr;
   logic           pend;

   logic [3:0]     cur_addr;
   logic [N-1:0]   word;
   logic           in_rng;
   logic           tx_load;
   logic [7:0]     tx_nx;
   logic           stage_ld;
   logic           addr_ld;
   logic           commit;
   logic           wr_hit;

   // Bits 6:4 of the command byte carry no meaning.
   logic           unused_cmd;
   assign unused_cmd = ^rx_byte[6:4];

`ifdef DDA_SNAPSHOT_EN
   logic [N-1:0]   snap;
`endif

   function automatic logic [N-1:0] rst_val(input int i);
      case (i)
         0:       rst_val = N'(16'hC000);
         1:       rst_val = N'(16'h14CD);
         2:       rst_val = N'(16'h14DD);
         3:       rst_val = N'(16'h14DD);
         default: rst_val = '0;
      endcase
   endfunction

   for (genvar g = 0; g < REG_SIZE; g++) begin : g_params
      assign params[g*N +: N] = regs[g];
   end

   // In IDLE the address comes straight from the command byte.
   always_comb begin
      cur_addr = (state == IDLE) ? rx_byte[3:0] : addr;
      in_rng   = 1'b0;
      word     = '0;
      for (int i = 0; i < REG_SIZE; i++) begin
         if (cur_addr == i[3:0]) begin
            in_rng = 1'b1;
            word   = regs[i];
         end
      end
      case (cur_addr)
         4'd8:    word = x;
         4'd9:    word = y;
         4'd15:   word = {{(N-1){1'b0}}, en_dda};
         default: ;
      endcase
`ifdef DDA_SNAPSHOT_EN
      if (state == RD_HI && (addr == 4'd8 || addr == 4'd9))
         word = snap;
`endif
   end

   always_comb begin
      state_nx = state;
      tx_load  = 1'b0;
      tx_nx    = 8'h00;
      stage_ld = 1'b0;
      addr_ld  = 1'b0;
      commit   = 1'b0;
      if (cs_n) begin
         state_nx = IDLE;
      end else if (rx_dv) begin
         case (state)
            IDLE: begin
               addr_ld = 1'b1;
               if (rx_byte[7]) begin
                  state_nx = WR_HI;
               end else begin
                  state_nx = RD_HI;
                  tx_load  = 1'b1;
                  tx_nx    = word[15:8];
               end
            end
            WR_HI: begin
               stage_ld = 1'b1;
               state_nx = WR_LO;
            end
            WR_LO: begin
               commit   = 1'b1;
               state_nx = IDLE;
            end
            RD_HI: begin
               tx_load  = 1'b1;
               tx_nx    = word[7:0];
               state_nx = RD_LO;
            end
            RD_LO: begin
               tx_load  = 1'b1;
               state_nx = IDLE;
            end
            default: state_nx = IDLE;
         endcase
      end
      wr_hit = commit && (in_rng || addr == 4'd15);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         stage    <= 8'h00;
         addr     <= 4'h0;
         pend     <= 1'b0;
         param_wr <= 1'b0;
         tx_dv    <= 1'b0;
         tx_byte  <= 8'h00;
         en_dda   <= 1'b1;
         for (int i = 0; i < REG_SIZE; i++)
            regs[i] <= rst_val(i);
      end else begin
         state    <= state_nx;
         tx_dv    <= tx_load;
         pend     <= wr_hit;
         param_wr <= pend;
         if (tx_load)
            tx_byte <= tx_nx;
         if (addr_ld)
            addr <= rx_byte[3:0];
         if (stage_ld)
            stage <= rx_byte;
         // Whole word lands in one edge: no half-updated parameter.
         if (commit) begin
            for (int i = 0; i < REG_SIZE; i++)
               if (addr == i[3:0])
                  regs[i] <= {stage, rx_byte};
            if (addr == 4'd15)
               en_dda <= rx_byte[0];
         end
      end
   end

`ifdef DDA_SNAPSHOT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         snap <= '0;
      else if (!cs_n && rx_dv && state == IDLE && !rx_byte[7]
               && (rx_byte[3:0] == 4'd8 || rx_byte[3:0] == 4'd9))
         snap <= word;
   end
`endif

endmodule

// File: tb/tb_spi_param_bridge.sv
// Randomized self-checking bench for spi_param_bridge.
// Compares byte-level responses against a register-level model.
module tb_spi_param_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        cs_n;
   logic        rx_dv;
   logic [7:0]  rx_byte;
   logic        tx_dv;
   logic [7:0]  tx_byte;
   logic [15:0] x;
   logic [15:0] y;
   logic [63:0] params;
   logic        en_dda;
   logic        param_wr;

   spi_param_bridge #(.N(16), .REG_SIZE(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .cs_n     (cs_n),
      .rx_dv    (rx_dv),
      .rx_byte  (rx_byte),
      .tx_dv    (tx_dv),
      .tx_byte  (tx_byte),
      .x        (x),
      .y        (y),
      .params   (params),
      .en_dda   (en_dda),
      .param_wr (param_wr)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [15:0] m_p [4];
   logic        m_en;
   int          exp_pw = 0;
   int          exp_tx = 0;
   int          pw_cnt = 0;
   int          tx_cnt = 0;
   int          consec = 0;
   logic        prev_dv = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         prev_dv = 1'b0;
      end else begin
         if (tx_dv) tx_cnt++;
         if (tx_dv && prev_dv) consec++;
         prev_dv = tx_dv;
         if (param_wr) pw_cnt++;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] m_flat();
      return {m_p[3], m_p[2], m_p[1], m_p[0]};
   endfunction

   function automatic logic [15:0] m_word(input int a);
      if (a < 4)   return m_p[a];
      if (a == 8)  return x;
      if (a == 9)  return y;
      if (a == 15) return {15'h0, m_en};
      return 16'h0000;
   endfunction

   task automatic m_reset();
      m_p[0] = 16'hC000;
      m_p[1] = 16'h14CD;
      m_p[2] = 16'h14DD;
      m_p[3] = 16'h14DD;
      m_en   = 1'b1;
   endtask

   // Result at n1 is the response one clock after the byte.
   task automatic send(input logic [7:0] b, output logic [8:0] rsp,
                       output logic pw1, output logic pw2,
                       output logic [63:0] p1);
      @(negedge clk);
      rx_byte = b;
      rx_dv   = 1'b1;
      @(negedge clk);
      rsp   = {tx_dv, tx_byte};
      pw1   = param_wr;
      p1    = params;
      rx_dv = 1'b0;
      @(negedge clk);
      pw2 = param_wr;
      @(negedge clk);
   endtask

   task automatic do_write(input int a, input logic [15:0] w);
      logic [8:0]  r;
      logic        p1, p2;
      logic [63:0] pv;
      logic        hit;
      hit = (a < 4) || (a == 15);
      send({1'b1, 3'($urandom), 4'(a)}, r, p1, p2, pv);
      chk("wr_cmd_dv", 64'(r[8]), 0);
      send(w[15:8], r, p1, p2, pv);
      chk("wr_hi_dv", 64'(r[8]), 0);
      send(w[7:0], r, p1, p2, pv);
      if (a < 4) m_p[a] = w;
      if (a == 15) m_en = w[0];
      if (hit) exp_pw++;
      chk("wr_commit", pv, m_flat());
      chk("wr_pw_early", 64'(p1), 0);
      chk("wr_pw", 64'(p2), 64'(hit));
      chk("wr_en", 64'(en_dda), 64'(m_en));
   endtask

   task automatic do_read(input int a);
      logic [8:0]  r;
      logic        p1, p2;
      logic [63:0] pv;
      logic [15:0] w;
      w = m_word(a);
      send({1'b0, 3'($urandom), 4'(a)}, r, p1, p2, pv);
      chk("rd_hi", 64'(r), 64'({1'b1, w[15:8]}));
      send(8'($urandom), r, p1, p2, pv);
      chk("rd_lo", 64'(r), 64'({1'b1, w[7:0]}));
      send(8'($urandom), r, p1, p2, pv);
      chk("rd_fill", 64'(r), 64'({1'b1, 8'h00}));
      exp_tx += 3;
   endtask

   initial begin
      logic [8:0]  r;
      logic        p1, p2;
      logic [63:0] pv;
      rst     = 1'b1;
      cs_n    = 1'b0;
      rx_dv   = 1'b0;
      rx_byte = 8'h00;
      x       = 16'h0;
      y       = 16'h0;
      m_reset();
      repeat (3) @(negedge clk);
      chk("rst_params", params, m_flat());
      chk("rst_en", 64'(en_dda), 1);
      chk("rst_tx_dv", 64'(tx_dv), 0);
      chk("rst_tx_byte", 64'(tx_byte), 0);
      chk("rst_pw", 64'(param_wr), 0);
      rst = 1'b0;
      @(negedge clk);

      do_read(0);
      do_write(2, 16'h3ABC);
      do_read(2);

      // Abort by cs_n before lo byte.
      send(8'h82, r, p1, p2, pv);
      send(8'h11, r, p1, p2, pv);
      cs_n = 1'b1;
      @(negedge clk);
      cs_n = 1'b0;
      @(negedge clk);
      chk("abort_params", params, m_flat());
      do_read(2);

      // Lo byte arrives together with cs_n rising: dropped.
      send(8'h82, r, p1, p2, pv);
      send(8'h33, r, p1, p2, pv);
      rx_byte = 8'h44;
      rx_dv   = 1'b1;
      cs_n    = 1'b1;
      @(negedge clk);
      rx_dv = 1'b0;
      cs_n  = 1'b0;
      repeat (3) @(negedge clk);
      chk("coinc_params", params, m_flat());
      do_read(2);

      do_write(15, 16'h0000);
      do_read(15);
      do_write(15, 16'h0001);
      do_write(9, 16'hFFFF);
      do_write(12, 16'h1234);
      do_read(12);

      // x changes between hi and lo loads.
      x = 16'h1234;
      send(8'h08, r, p1, p2, pv);
      chk("strad_hi", 64'(r), 64'({1'b1, 8'h12}));
      x = 16'h5678;
      send(8'h00, r, p1, p2, pv);
`ifdef DDA_SNAPSHOT_EN
      chk("strad_lo", 64'(r), 64'({1'b1, 8'h34}));
`else
      chk("strad_lo", 64'(r), 64'({1'b1, 8'h78}));
`endif
      send(8'h00, r, p1, p2, pv);
      chk("strad_fill", 64'(r), 64'({1'b1, 8'h00}));
      exp_tx += 3;

      for (int k = 0; k < 60; k++) begin
         int a;
         x = 16'($urandom);
         y = 16'($urandom);
         a = (k % 3 == 0) ? int'($urandom_range(0, 15))
                          : int'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1)
            do_write(a, 16'($urandom));
         else
            do_read(a);
      end

      // Reset in the middle of a write frame.
      do_write(15, 16'h0000);
      send(8'h81, r, p1, p2, pv);
      send(8'h55, r, p1, p2, pv);
      rst = 1'b1;
      @(negedge clk);
      m_reset();
      chk("mid_rst_params", params, m_flat());
      chk("mid_rst_en", 64'(en_dda), 1);
      rst = 1'b0;
      @(negedge clk);
      do_read(1);

      repeat (3) @(negedge clk);
      chk("tx_count", 64'(tx_cnt), 64'(exp_tx));
      chk("pw_count", 64'(pw_cnt), 64'(exp_pw));
      chk("tx_consec", 64'(consec), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
